// File: rtl/ram_bus_master_pkg.sv
// Shared RAM-bus constants and the master's state encoding.
package ram_bus_master_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WR_WAIT,
        ST_WR_STB,
        ST_RD_EN,
        ST_RD_CAP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ram_bus_master_tristate_drv.sv
// Tri-state bus driver with a registered output enable and data latch.
// Shared by every block that puts data onto a common bus.
module bus_tristate_drv #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         oe_set,
    input  logic         oe_clr,
    input  logic [W-1:0] din,
    output logic         oe,
    inout  wire  [W-1:0] bus
);

    logic [W-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oe <= 1'b0;
            q  <= '0;
        end else if (oe_set) begin
            oe <= 1'b1;
            q  <= din;
        end else if (oe_clr) begin
            oe <= 1'b0;
        end
    end

    assign bus = oe ? q : {W{1'bz}};

endmodule

// File: rtl/ram_bus_master.sv
// RAM bus initiator: turns single/burst requests into ram_in / ram_out strobes
// and owns the direction of the shared ram_bus_8.
module ram_bus_master
    import ram_bus_master_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              ram_in,
    output logic              ram_out,
    output logic [ADDR_W-1:0] ram_add_4,
    inout  wire  [DATA_W-1:0] ram_bus_8
);

    state_t            state;
    logic              we_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] beat_cnt;
    logic [1:0]        lat_cnt;
    logic              drv_oe;
    logic              last_beat;
    logic              oe_set;
    logic              oe_clr;

    assign last_beat = (beat_cnt == len_q);
    // The driver enable tracks ram_in exactly: set on the write handshake, cleared after WR_STB.
    assign oe_set    = (state == ST_WR_WAIT) && wr_valid;
    assign oe_clr    = (state == ST_WR_STB);

    bus_tristate_drv #(.W(DATA_W)) u_drv (
        .clk    (clk),
        .rst    (rst),
        .oe_set (oe_set),
        .oe_clr (oe_clr),
        .din    (wdata),
        .oe     (drv_oe),
        .bus    (ram_bus_8)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            len_q     <= '0;
            beat_cnt  <= '0;
            lat_cnt   <= '0;
            wr_ready  <= 1'b0;
            rdata     <= '0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_in    <= 1'b0;
            ram_out   <= 1'b0;
            ram_add_4 <= '0;
        end else begin
            // NOTE: pulse outputs default low here so every branch yields a single-cycle pulse.
            rd_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        we_q      <= we;
                        len_q     <= len;
                        ram_add_4 <= addr;
                        beat_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (we_q) begin
                        wr_ready <= 1'b1;
                        state    <= ST_WR_WAIT;
                    end else begin
                        ram_out <= 1'b1;
                        lat_cnt <= '0;
                        state   <= ST_RD_EN;
                    end
                end
                ST_WR_WAIT: begin
                    if (wr_valid) begin
                        wr_ready <= 1'b0;
                        ram_in   <= 1'b1;
                        state    <= ST_WR_STB;
                    end
                end
                ST_RD_EN: begin
                    if (lat_cnt == 2'(READ_LAT - 1)) begin
                        ram_out  <= 1'b0;
                        rdata    <= ram_bus_8;
                        rd_valid <= 1'b1;
                        state    <= ST_RD_CAP;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                ST_WR_STB, ST_RD_CAP: begin
                    ram_in <= 1'b0;
                    if (last_beat) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        beat_cnt  <= beat_cnt + ADDR_W'(1);
                        ram_add_4 <= ram_add_4 + ADDR_W'(1);
                        state     <= ST_SETUP;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    a_strobe_excl: assert property (@(posedge clk) disable iff (rst) !(ram_in && ram_out));
    a_no_contention: assert property (@(posedge clk) disable iff (rst) !(drv_oe && ram_out));

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench: two masters (READ_LAT 1 and 3), each with a RAM model on its own tri-state bus.
module tb_ram_bus_master;

    typedef struct {
        bit         we;
        logic [3:0] addr;
        logic [3:0] len;
        int         stall;
        logic [7:0] d [4];
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req [2];
    logic       we_i [2];
    logic       wr_valid [2];
    logic [3:0] addr_i [2];
    logic [3:0] len_i [2];
    logic [7:0] wdata [2];
    logic       wr_ready [2];
    logic       rd_valid [2];
    logic       busy [2];
    logic       done [2];
    logic       ram_in [2];
    logic       ram_out [2];
    logic [3:0] add [2];
    logic [7:0] rdata [2];
    logic       probe_en [2];
    wire  [7:0] bus0;
    wire  [7:0] bus1;

    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];
    logic [7:0] model_mem [2][16];
    logic [7:0] beat_data [16];
    vec_t       vecs [7];
    int         checks = 0;
    int         errors = 0;

    always #10 clk = ~clk;

    ram_bus_master #(.READ_LAT(1)) dut (
        .clk(clk), .rst(rst), .req(req[0]), .we(we_i[0]), .addr(addr_i[0]), .len(len_i[0]),
        .wdata(wdata[0]), .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .rdata(rdata[0]),
        .rd_valid(rd_valid[0]), .busy(busy[0]), .done(done[0]), .ram_in(ram_in[0]),
        .ram_out(ram_out[0]), .ram_add_4(add[0]), .ram_bus_8(bus0)
    );

    ram_bus_master #(.READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req(req[1]), .we(we_i[1]), .addr(addr_i[1]), .len(len_i[1]),
        .wdata(wdata[1]), .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .rdata(rdata[1]),
        .rd_valid(rd_valid[1]), .busy(busy[1]), .done(done[1]), .ram_in(ram_in[1]),
        .ram_out(ram_out[1]), .ram_add_4(add[1]), .ram_bus_8(bus1)
    );

    // RAM drives the bus while ram_out is high; otherwise the bench may drive a probe
    // pattern to prove the master has released the bus.
    assign bus0 = (ram_out[0] || probe_en[0]) ? (ram_out[0] ? mem0[add[0]] : 8'h5A) : 8'hzz;
    assign bus1 = (ram_out[1] || probe_en[1]) ? (ram_out[1] ? mem1[add[1]] : 8'h5A) : 8'hzz;

    always @(posedge clk) begin
        if (ram_in[0]) mem0[add[0]] <= bus0;
        if (ram_in[1]) mem1[add[1]] <= bus1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("strobe_excl0", 32'(ram_in[0] & ram_out[0]), 32'd0);
            check("strobe_excl1", 32'(ram_in[1] & ram_out[1]), 32'd0);
        end
    end

    function automatic logic [7:0] bus_of(input int k);
        return (k == 0) ? bus0 : bus1;
    endfunction

    function automatic logic [7:0] mem_of(input int k, input int i);
        return (k == 0) ? mem0[i] : mem1[i];
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [3:0] wrap(input logic [3:0] a, input int i);
        return 4'((int'(a) + i) % 16);
    endfunction

    function automatic vec_t mk(input bit w, input logic [3:0] a, input logic [3:0] l, input int s,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3);
        vec_t v;
        v.we = w; v.addr = a; v.len = l; v.stall = s;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        return v;
    endfunction

    task automatic probe_check(input int k, input string nm);
        probe_en[k] = 1'b1;
        #1;
        check(nm, bus_of(k), 8'h5A);
        probe_en[k] = 1'b0;
    endtask

    // One complete transaction; beat_data holds write data or expected read data.
    task automatic run_txn(input int k, input bit w, input logic [3:0] a, input logic [3:0] l,
                           input int stall);
        int beats, per, n, wb, ib, rb, oe_cyc, st;
        bit got;
        beats = int'(l) + 1;
        per = w ? 3 : 2 + lat_of(k);
        n = 0; wb = 0; ib = 0; rb = 0; oe_cyc = 0; st = stall; got = 1'b0;
        @(negedge clk);
        check("idle_busy", busy[k], 0);
        req[k] = 1'b1; we_i[k] = w; addr_i[k] = a; len_i[k] = l;
        @(negedge clk);
        req[k] = 1'b0;
        n = 1;
        while (!got && n < 400) begin
            check("busy_high", busy[k], 1);
            if (wr_ready[k]) begin
                if (st > 0) begin
                    st--;
                    wr_valid[k] = 1'b0;
                    check("stall_ram_in", ram_in[k], 0);
                    probe_check(k, "stall_bus_released");
                end else begin
                    wr_valid[k] = 1'b1;
                    wdata[k] = beat_data[wb & 15];
                    wb++;
                end
            end else begin
                wr_valid[k] = 1'b0;
            end
            if (ram_in[k]) begin
                check("wr_bus", bus_of(k), beat_data[ib & 15]);
                check("wr_addr", add[k], wrap(a, ib));
                ib++;
            end
            if (ram_out[k]) begin
                oe_cyc++;
                check("rd_addr", add[k], wrap(a, rb));
            end
            if (rd_valid[k]) begin
                check("rdata", rdata[k], beat_data[rb & 15]);
                rb++;
            end
            if (done[k]) got = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        wr_valid[k] = 1'b0;
        check("done_seen", got, 1);
        check("latency", n, beats * per + stall + 1);
        if (w) check("wr_beats", ib, beats);
        else begin
            check("rd_beats", rb, beats);
            check("oe_cycles", oe_cyc, beats * lat_of(k));
        end
        @(negedge clk);
        check("done_one_cycle", done[k], 0);
        check("busy_clear", busy[k], 0);
        if (w) for (int i = 0; i < beats; i++) model_mem[k][wrap(a, i)] = beat_data[i];
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req[k] = 0; we_i[k] = 0; wr_valid[k] = 0; addr_i[k] = 0; len_i[k] = 0;
            wdata[k] = 0; probe_en[k] = 0;
        end
        vecs[0] = mk(1, 4'd3,  4'd0, 0, 8'hAF, 8'h00, 8'h00, 8'h00);
        vecs[1] = mk(0, 4'd3,  4'd0, 0, 8'hAF, 8'h00, 8'h00, 8'h00);
        vecs[2] = mk(1, 4'd14, 4'd3, 1, 8'h11, 8'h22, 8'h33, 8'h44);
        vecs[3] = mk(0, 4'd14, 4'd3, 0, 8'h11, 8'h22, 8'h33, 8'h44);
        vecs[4] = mk(0, 4'd15, 4'd1, 0, 8'h22, 8'h33, 8'h00, 8'h00);
        vecs[5] = mk(1, 4'd0,  4'd0, 0, 8'h5C, 8'h00, 8'h00, 8'h00);
        vecs[6] = mk(0, 4'd15, 4'd2, 0, 8'h22, 8'h5C, 8'h44, 8'h00);

        // Reset held three cycles: every output idle and the bus released.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_wr_ready", wr_ready[k], 0);
            check("rst_rd_valid", rd_valid[k], 0);
            check("rst_busy", busy[k], 0);
            check("rst_done", done[k], 0);
            check("rst_ram_in", ram_in[k], 0);
            check("rst_ram_out", ram_out[k], 0);
            check("rst_addr", add[k], 0);
            check("rst_rdata", rdata[k], 0);
            probe_check(k, "rst_bus_released");
        end
        rst = 1'b0;

        // Fill both RAMs with a 16-beat burst (exercises len=15 and full wrap).
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) beat_data[i] = 8'($urandom);
            run_txn(k, 1'b1, 4'd0, 4'd15, 0);
        end

        for (int v = 0; v < 7; v++) begin
            for (int j = 0; j < 4; j++) beat_data[j] = vecs[v].d[j];
            run_txn(0, vecs[v].we, vecs[v].addr, vecs[v].len, vecs[v].stall);
        end

        // Write stall: five cycles with wr_valid low.
        beat_data[0] = 8'hC3;
        run_txn(0, 1'b1, 4'd6, 4'd0, 5);

        // READ_LAT=3 instance: burst write then read back across the wrap.
        beat_data[0] = 8'h11; beat_data[1] = 8'h22; beat_data[2] = 8'h33; beat_data[3] = 8'h44;
        run_txn(1, 1'b1, 4'd14, 4'd3, 0);
        run_txn(1, 1'b0, 4'd14, 4'd3, 0);

        // req raised during DONE is ignored; held into IDLE it is accepted.
        begin
            int n;
            @(negedge clk);
            req[0] = 1'b1; we_i[0] = 1'b0; addr_i[0] = 4'd3; len_i[0] = 4'd0;
            @(negedge clk);
            req[0] = 1'b0;
            n = 0;
            while (!done[0] && n < 20) begin @(negedge clk); n++; end
            check("req_done_reach", done[0], 1);
            req[0] = 1'b1;
            @(negedge clk);
            check("req_in_done_ignored", busy[0], 0);
            @(negedge clk);
            check("req_held_accepted", busy[0], 1);
            req[0] = 1'b0;
            n = 0;
            while (!rd_valid[0] && n < 20) begin @(negedge clk); n++; end
            check("req_held_rdata", rdata[0], 8'hAF);
            n = 0;
            while (!done[0] && n < 20) begin @(negedge clk); n++; end
            check("req_held_done", done[0], 1);
            @(negedge clk);
        end

        // Reset during the second beat of a write burst: RAM[8] written, RAM[9] untouched.
        begin
            int n, wb, ib;
            bit hit;
            for (int i = 0; i < 4; i++) beat_data[i] = 8'hE0 + 8'(i);
            @(negedge clk);
            req[0] = 1'b1; we_i[0] = 1'b1; addr_i[0] = 4'd8; len_i[0] = 4'd3;
            @(negedge clk);
            req[0] = 1'b0;
            n = 0; wb = 0; ib = 0; hit = 1'b0;
            while (!hit && n < 40) begin
                if (ram_in[0]) ib++;
                if (ib == 2) begin
                    hit = 1'b1;
                    rst = 1'b1;
                    wr_valid[0] = 1'b0;
                    #1;
                    check("abort_ram_in", ram_in[0], 0);
                    check("abort_ram_out", ram_out[0], 0);
                    check("abort_busy", busy[0], 0);
                    check("abort_wr_ready", wr_ready[0], 0);
                    probe_check(0, "abort_bus_released");
                end else begin
                    if (wr_ready[0]) begin
                        wr_valid[0] = 1'b1; wdata[0] = beat_data[wb & 3]; wb++;
                    end else wr_valid[0] = 1'b0;
                    @(negedge clk);
                    n++;
                end
            end
            check("abort_wr_reached", hit, 1);
            model_mem[0][8] = beat_data[0];
            repeat (2) begin
                @(negedge clk);
                check("abort_no_done", done[0], 0);
            end
            rst = 1'b0;
        end

        // Reset during the second beat of a read burst: no rd_valid or done afterwards.
        begin
            int n, rb;
            bit hit;
            @(negedge clk);
            req[0] = 1'b1; we_i[0] = 1'b0; addr_i[0] = 4'd4; len_i[0] = 4'd3;
            @(negedge clk);
            req[0] = 1'b0;
            n = 0; rb = 0; hit = 1'b0;
            while (!hit && n < 40) begin
                if (rd_valid[0]) rb++;
                if (rb == 1 && ram_out[0]) begin
                    hit = 1'b1;
                    rst = 1'b1;
                    #1;
                    check("abort_rd_ram_out", ram_out[0], 0);
                    check("abort_rd_valid", rd_valid[0], 0);
                    check("abort_rd_busy", busy[0], 0);
                end else begin
                    @(negedge clk);
                    n++;
                end
            end
            check("abort_rd_reached", hit, 1);
            repeat (2) begin
                @(negedge clk);
                check("abort_rd_no_pulse", 32'(rd_valid[0] | done[0]), 0);
            end
            rst = 1'b0;
        end

        // Randomised transactions against the array model.
        for (int t = 0; t < 40; t++) begin
            int k;
            bit w;
            logic [3:0] a, l;
            k = (t % 4 == 3) ? 1 : 0;
            w = 1'($urandom_range(0, 1));
            a = 4'($urandom);
            l = 4'($urandom_range(0, 5));
            if (w) for (int i = 0; i < 16; i++) beat_data[i] = 8'($urandom);
            else for (int i = 0; i < 16; i++) beat_data[i] = model_mem[k][wrap(a, i)];
            run_txn(k, w, a, l, w ? int'($urandom_range(0, 2)) : 0);
        end

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++)
                check("ram_contents", mem_of(k, i), model_mem[k][i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
